// File: rtl/fft_pkg.sv
// Shared FFT pipeline definitions: SDF stage state encoding and
// elaboration-time helpers for counter and twiddle sizing.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        BFLY  = 2'd2,
        DRAIN = 2'd3
    } sdf_state_t;

    function automatic int clog2_min1(input int value);
        return ($clog2(value) < 1) ? 1 : $clog2(value);
    endfunction

    // Twiddle step per sample index for a stage whose delay buffer is m deep.
    function automatic int tw_stride(input int n, input int m);
        return n / (2 * m);
    endfunction

endpackage

// File: rtl/sdf_stage_ctrl.sv
// Sequencing controller for one SDF FFT stage: frame index tracking, mux select,
// twiddle addressing, output framing and self-generated drain of the delay buffer.
module sdf_stage_ctrl
    import fft_pkg::*;
#(
    parameter  int N     = 16,
    parameter  int M     = 8,
    localparam int CNT_W = clog2_min1(M),
    localparam int TW_W  = clog2_min1(N / 2)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            valid_in,
    input  logic            frame_start,
    output logic            bf_sel,
    output logic            buf_shift,
    output logic            drain_active,
    output logic [TW_W-1:0] tw_addr,
    output logic            out_valid,
    output logic            out_sop,
    output logic            out_eop,
    output logic            sync_err,
    output logic            busy
);

    localparam int IDX_W  = CNT_W + 1;
    localparam int TWP_W  = CNT_W + TW_W;
    localparam int STRIDE = tw_stride(N, M);

    localparam logic [IDX_W-1:0] IDX_ZERO   = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_FILL  = IDX_W'(M - 1);
    localparam logic [IDX_W-1:0] FIRST_BFLY = IDX_W'(M);
    localparam logic [IDX_W-1:0] LAST_BFLY  = IDX_W'(2 * M - 1);

    sdf_state_t       state_r, state_n;
    logic [IDX_W-1:0] idx_r, idx_n;
    logic             pend_r, pend_n;
    logic             fire_s;
    logic             restart_s;
    logic [TW_W-1:0]  tw_s;

    assign tw_s = TW_W'(TWP_W'(idx_r[CNT_W-1:0]) * TWP_W'(STRIDE));

    // State, index and pending-lower-half registers; everything else is derived.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= IDX_ZERO;
            pend_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
            pend_r  <= pend_n;
        end
    end

    // Next-state sequencing plus zero-latency datapath controls.
    always_comb begin
        state_n      = state_r;
        idx_n        = idx_r;
        pend_n       = pend_r;
        bf_sel       = 1'b0;
        tw_addr      = TW_W'(0);
        out_valid    = 1'b0;
        out_sop      = 1'b0;
        out_eop      = 1'b0;
        sync_err     = 1'b0;
        drain_active = (state_r == DRAIN) && !valid_in;
        fire_s       = (valid_in || drain_active) && !stall;
        restart_s    = fire_s && frame_start && (idx_r != IDX_ZERO);
        buf_shift    = fire_s;
        busy         = (state_r != IDLE);

        case (state_r)
            IDLE: begin
                if (fire_s && frame_start) begin
                    state_n = FILL;
                    idx_n   = IDX_ONE;
                end else if (fire_s) begin
                    sync_err = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            FILL: begin
                tw_addr = tw_s;
                if (restart_s) begin
                    sync_err = 1'b1;
                    state_n  = FILL;
                    idx_n    = IDX_ONE;
                    pend_n   = 1'b0;
                end else if (fire_s) begin
                    // Buffer output is the previous frame's lower half only while pend is set.
                    out_valid = pend_r;
                    idx_n     = idx_r + IDX_ONE;
                    if (idx_r == LAST_FILL) begin
                        out_eop = pend_r;
                        pend_n  = 1'b0;
                        state_n = BFLY;
                    end else begin
                        state_n = FILL;
                    end
                end else begin
                    state_n = FILL;
                end
            end
            BFLY: begin
                bf_sel  = 1'b1;
                tw_addr = tw_s;
                if (restart_s) begin
                    sync_err = 1'b1;
                    state_n  = FILL;
                    idx_n    = IDX_ONE;
                    pend_n   = 1'b0;
                end else if (fire_s) begin
                    out_valid = 1'b1;
                    out_sop   = (idx_r == FIRST_BFLY);
                    if (idx_r == LAST_BFLY) begin
                        idx_n   = IDX_ZERO;
                        pend_n  = 1'b1;
                        state_n = DRAIN;
                    end else begin
                        idx_n   = idx_r + IDX_ONE;
                    end
                end else begin
                    state_n = BFLY;
                end
            end
            DRAIN: begin
                tw_addr = tw_s;
                if (fire_s) begin
                    out_valid = 1'b1;
                    out_eop   = (idx_r == LAST_FILL);
                    sync_err  = valid_in && !frame_start;
                    // A framed sample here continues the index seamlessly into a new fill.
                    if (idx_r == LAST_FILL) begin
                        pend_n = 1'b0;
                        if (valid_in && frame_start) begin
                            state_n = BFLY;
                            idx_n   = idx_r + IDX_ONE;
                        end else begin
                            state_n = IDLE;
                            idx_n   = IDX_ZERO;
                        end
                    end else begin
                        idx_n   = idx_r + IDX_ONE;
                        state_n = (valid_in && frame_start) ? FILL : DRAIN;
                    end
                end else begin
                    state_n = DRAIN;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = IDX_ZERO;
                pend_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Directed bench for sdf_stage_ctrl (N=16, M=8): per-cycle expected controls are
// queued as stimulus is driven and checked at the following falling edge.
module tb_sdf_stage_ctrl;

    logic       clk;
    logic       rst;
    logic       stall;
    logic       valid_in;
    logic       frame_start;
    logic       bf_sel;
    logic       buf_shift;
    logic       drain_active;
    logic [2:0] tw_addr;
    logic       out_valid;
    logic       out_sop;
    logic       out_eop;
    logic       sync_err;
    logic       busy;

    typedef struct packed {
        logic       bf;
        logic       vld;
        logic       sop;
        logic       eop;
        logic       drn;
        logic       err;
        logic       bsy;
        logic       shf;
        logic [2:0] tw;
    } exp_t;

    exp_t sb[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   vld_seen = 0;

    sdf_stage_ctrl #(.N(16), .M(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .valid_in     (valid_in),
        .frame_start  (frame_start),
        .bf_sel       (bf_sel),
        .buf_shift    (buf_shift),
        .drain_active (drain_active),
        .tw_addr      (tw_addr),
        .out_valid    (out_valid),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .sync_err     (sync_err),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic bf, input logic vld, input logic sop,
                                input logic eop, input logic drn, input logic err,
                                input logic bsy, input logic shf, input logic [2:0] tw);
        exp_t e;
        e.bf = bf; e.vld = vld; e.sop = sop; e.eop = eop; e.drn = drn;
        e.err = err; e.bsy = bsy; e.shf = shf; e.tw = tw;
        return e;
    endfunction

    // Expected controls for sample i of a frame with no stall.
    function automatic exp_t samp(input int i, input logic from_idle, input logic prev_pend);
        return mk(i >= 8, (i >= 8) || prev_pend, i == 8, prev_pend && (i == 7),
                  1'b0, 1'b0, !(from_idle && (i == 0)), 1'b1, 3'(i));
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic drive(input logic v, input logic fs, input logic st, input exp_t e);
        exp_t x;
        valid_in    = v;
        frame_start = fs;
        stall       = st;
        sb.push_back(e);
        @(negedge clk);
        x = sb.pop_front();
        chk("bf_sel",       {7'b0, bf_sel},       {7'b0, x.bf});
        chk("out_valid",    {7'b0, out_valid},    {7'b0, x.vld});
        chk("out_sop",      {7'b0, out_sop},      {7'b0, x.sop});
        chk("out_eop",      {7'b0, out_eop},      {7'b0, x.eop});
        chk("drain_active", {7'b0, drain_active}, {7'b0, x.drn});
        chk("sync_err",     {7'b0, sync_err},     {7'b0, x.err});
        chk("busy",         {7'b0, busy},         {7'b0, x.bsy});
        chk("buf_shift",    {7'b0, buf_shift},    {7'b0, x.shf});
        chk("tw_addr",      {5'b0, tw_addr},      {5'b0, x.tw});
        if (out_valid === 1'b1) vld_seen++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
    endtask

    task automatic run_frame(input logic from_idle, input logic prev_pend, input int first);
        for (int i = first; i < 16; i++) drive(1'b1, i == 0, 1'b0, samp(i, from_idle, prev_pend));
    endtask

    task automatic drain_all();
        for (int d = 0; d < 8; d++) drive(1'b0, 1'b0, 1'b0, mk(0, 1, 0, d == 7, 1, 0, 1, 1, 3'(d)));
    endtask

    task automatic do_reset(input int n);
        rst         = 1'b1;
        valid_in    = 1'b0;
        frame_start = 1'b0;
        stall       = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        valid_in    = 1'b0;
        frame_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(2);

        // single frame then drain
        run_frame(1'b1, 1'b0, 0);
        drain_all();
        idle_cycles(1);

        // back-to-back frames: 24 contiguous valid outputs
        vld_seen = 0;
        run_frame(1'b1, 1'b0, 0);
        run_frame(1'b0, 1'b1, 0);
        chk("b2b_valid_count", 8'(vld_seen), 8'd24);
        drain_all();
        idle_cycles(1);

        // gaps after sample 3, stall at sample 11
        vld_seen = 0;
        for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 1'b0, samp(i, 1'b1, 1'b0));
        for (int k = 0; k < 2; k++) drive(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 1, 0, 3'd4));
        for (int i = 4; i < 11; i++) drive(1'b1, 1'b0, 1'b0, samp(i, 1'b1, 1'b0));
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b1, mk(1, 0, 0, 0, 0, 0, 1, 0, 3'd3));
        for (int i = 11; i < 16; i++) drive(1'b1, 1'b0, 1'b0, samp(i, 1'b1, 1'b0));
        drain_all();
        chk("stall_valid_count", 8'(vld_seen), 8'd16);
        idle_cycles(1);

        // mid-frame frame_start at sample 5 restarts the frame
        vld_seen = 0;
        for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 1'b0, samp(i, 1'b1, 1'b0));
        drive(1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 1, 1, 1, 3'd5));
        run_frame(1'b0, 1'b0, 1);
        drain_all();
        chk("restart_valid_count", 8'(vld_seen), 8'd16);
        idle_cycles(1);

        // unframed sample in IDLE, then the same sample while stalled
        drive(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1, 0, 1, 3'd0));
        drive(1'b1, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
        idle_cycles(1);

        // reset held two cycles mid-BFLY
        for (int i = 0; i < 10; i++) drive(1'b1, i == 0, 1'b0, samp(i, 1'b1, 1'b0));
        do_reset(2);
        idle_cycles(9);

        // reset at drain cycle 4
        run_frame(1'b1, 1'b0, 0);
        for (int d = 0; d < 4; d++) drive(1'b0, 1'b0, 1'b0, mk(0, 1, 0, 0, 1, 0, 1, 1, 3'(d)));
        do_reset(1);
        vld_seen = 0;
        idle_cycles(9);
        chk("post_reset_valid_count", 8'(vld_seen), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdf_stage_ctrl.md
Name: sdf_stage_ctrl

Overview:
Sequencing controller for one single-path delay-feedback (SDF) stage of the 16-point FFT pipeline.
- Tracks the sample index within a frame and drives the stage mux (fill vs butterfly).
- Generates the twiddle ROM address and marks valid output samples.
- Self-generates drain cycles so the stage's M-deep delay buffer empties after the last frame.
- Sits beside each stage's delay buffer and butterfly; honours the global pipeline stall.

Parameters:
N, 16, FFT size in points; power of 2.
M, 8, delay-buffer depth of this stage; power of 2, 1 <= M <= N/2.
CNT_W, $clog2(M) (min 1), sample-index counter width (derived, not overridden).
TW_W, $clog2(N/2), twiddle address width (derived).

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  freezes all state; no counter or state change while high
valid_in  input  1  input sample present this cycle
frame_start  input  1  qualifies valid_in as sample 0 of a new frame
bf_sel  output  1  0 = fill (input to buffer, buffer to output), 1 = butterfly
buf_shift  output  1  delay buffer must advance this cycle (= fire)
drain_active  output  1  controller-generated shift; datapath feeds zero into buffer
tw_addr  output  TW_W  twiddle ROM address for the sample leaving on the lower path
out_valid  output  1  stage output sample valid this cycle
out_sop  output  1  first output sample of a frame
out_eop  output  1  last output sample of a frame
sync_err  output  1  one-cycle pulse on framing violation
busy  output  1  state != IDLE

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE, idx=0, pend=0.
  - All outputs 0 the following cycle, including bf_sel, tw_addr, drain_active and sync_err.
  - Reset mid-frame or mid-drain abandons all data; no out_valid for it.
- fire = (valid_in | drain_active) & !stall.
  - idx, state and pend update only on fire.
  - All outputs are combinational from registered state/idx/pend plus the current valid_in and stall; zero-cycle latency to the datapath.
- States:
  - IDLE: bf_sel=0.
    - valid_in & frame_start -> FILL, idx=1 (this sample is idx 0).
    - valid_in without frame_start -> sample dropped, sync_err pulse.
  - FILL (idx 0..M-1): bf_sel=0.
    - Each fire increments idx; at idx M-1 -> BFLY.
    - When pend=1, the buffer output is the previous frame's lower half: out_valid=fire, tw_addr=idx*(N/(2M)).
    - out_eop at idx M-1 when pend=1; pend clears there.
  - BFLY (idx M..2M-1): bf_sel=1, out_valid=fire (upper outputs).
    - out_sop at idx M.
    - At idx 2M-1 fire: pend=1, idx wraps to 0, next state DRAIN.
  - DRAIN (idx 0..M-1): drain_active=!valid_in, bf_sel=0.
    - Outputs and tw_addr exactly as in FILL with pend=1.
    - valid_in & frame_start during DRAIN: seamless switch to FILL at the same idx; the new sample shifts in.
    - valid_in without frame_start: sync_err, sample dropped, drain continues.
    - At idx M-1 fire -> IDLE, pend=0.
- Back-to-back frames: frame_start on the cycle after sample 2M-1 gives contiguous out_valid with no drain cycles.
- frame_start with valid_in while in FILL/BFLY at idx != 0 (mid-frame):
  - sync_err pulse; partial frame abandoned.
  - idx restarts: this sample is idx 0, state FILL, pend=0.
- valid_in low gaps: no fire; idx holds; out_valid=0.
- stall high:
  - out_valid, out_sop, out_eop, buf_shift = 0.
  - bf_sel, tw_addr, drain_active hold their values.
  - A sync_err triggered by a stalled sample is suppressed.
- idx wraps modulo 2M. tw_addr = idx[CNT_W-1:0] * (N/(2M)), truncated to TW_W bits.

Decomposition:
- fft_pkg (shared): sdf_state_t enum {IDLE, FILL, BFLY, DRAIN}, localparam function for clog2-with-minimum-1, twiddle stride helper N/(2M).
- No sub-module; counter and FSM live in one always_ff plus one always_comb.

Test Plan:
- Reset: hold rst 2 cycles mid-BFLY -> next cycle busy=0, bf_sel=0, out_valid=0, tw_addr=0; 8 subsequent cycles with valid_in=0 produce no drain.
- Single frame (N=16, M=8): frame_start + 16 contiguous valid, no stall.
  - bf_sel=0 for samples 0-7, 1 for 8-15.
  - out_valid on 8-15 with out_sop at sample 8.
  - Then 8 DRAIN cycles: drain_active=1, tw_addr 0..7, out_eop on the 8th; then busy=0.
- Back-to-back: two frames of 16 with no gap -> 24 contiguous out_valid cycles starting at sample 8 of frame 1.
  - No drain_active between frames; tw_addr 0..7 during frame-2 samples 0-7.
- Stall/gaps: stall high 3 cycles at sample 11; valid_in low 2 cycles after sample 3.
  - idx and bf_sel frozen throughout; out_valid=0 during stall.
  - Total out_valid count is still 16.
- Framing errors:
  - Mid-frame frame_start at sample 5 -> sync_err 1 cycle; restart with idx 0; only the new frame's 16 outputs appear.
  - valid_in without frame_start in IDLE -> sync_err, busy stays 0.
- Reset during DRAIN at drain cycle 4 -> drain_active=0 next cycle, no further out_valid or out_eop.
